// File: rtl/tow_audio_pkg.sv
// rtl/tow_audio_pkg.sv - shared types and default constants for the tug-of-war audio path
package tow_audio_pkg;

  typedef enum logic [1:0] {
    QUIET = 2'd0,
    HOLD  = 2'd1,
    REARM = 2'd2
  } clap_state_e;

  localparam int CLK_DIV_DEF  = 25;
  localparam int DECIM_DEF    = 128;
  localparam int SAMPLE_W_DEF = 8;
  localparam int THRESH_DEF   = 16;
  localparam int HYST_DEF     = 4;
  localparam int HOLDOFF_DEF  = 4096;

  // Bits needed for |ones - decim/2|, which spans 0..decim/2.
  function automatic int dev_width(input int decim);
    return $clog2(decim / 2 + 1);
  endfunction

endpackage

// File: rtl/mic_clk_gen.sv
// rtl/mic_clk_gen.sv - microphone clock divider with a strobe on each mic_clk falling toggle
module mic_clk_gen
  import tow_audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mic_clk,
  output logic sample_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             mic_clk_q, mic_clk_d;
  logic             wrap;

  always_comb begin
    wrap      = en && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    mic_clk_d = mic_clk_q;
    if (!en) begin
      div_cnt_d = '0;
      mic_clk_d = 1'b0;
    end else if (wrap) begin
      div_cnt_d = '0;
      mic_clk_d = ~mic_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      mic_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mic_clk_q <= mic_clk_d;
    end
  end

  assign mic_clk     = mic_clk_q;
  // The mic drives data after rising mic_clk, so the falling toggle sees a settled bit.
  assign sample_tick = wrap && mic_clk_q;

endmodule

// File: rtl/pdm_mic_receiver.sv
// rtl/pdm_mic_receiver.sv - PDM mic decimator with level tracking and clap detection
module pdm_mic_receiver
  import tow_audio_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int DECIM    = DECIM_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int THRESH   = THRESH_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int HOLDOFF  = HOLDOFF_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mic_data,
  output logic                mic_clk,
  output logic                mic_lrsel,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic [SAMPLE_W-2:0] level,
  output logic                clap
);

  localparam int LEVEL_W = SAMPLE_W - 1;
  localparam int DEV_W   = dev_width(DECIM);
  localparam int BIT_W   = $clog2(DECIM);
  localparam int HOLD_W  = $clog2(HOLDOFF + 2);

  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DECIM - 1);
  localparam logic [SAMPLE_W-1:0] MID       = SAMPLE_W'(DECIM / 2);
  localparam logic [LEVEL_W-1:0]  THRESH_L  = LEVEL_W'(THRESH);
  localparam logic [LEVEL_W-1:0]  REARM_L   = LEVEL_W'(THRESH - HYST);
  localparam logic [HOLD_W-1:0]   HOLDOFF_L = HOLD_W'(HOLDOFF);

  logic sample_tick;

  mic_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_mic_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mic_clk    (mic_clk),
    .sample_tick(sample_tick)
  );

  logic [1:0]          sync_q, sync_d;
  logic [SAMPLE_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                sample_valid_q, sample_valid_d;
  clap_state_e         state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                clap_q, clap_d;

  logic                pdm_bit;
  logic [SAMPLE_W-1:0] win_sum;
  logic [DEV_W-1:0]    dev_c;

  assign pdm_bit = sync_q[1];

  always_comb begin
    sync_d         = {sync_q[0], mic_data};
    ones_cnt_d     = ones_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    sample_d       = sample_q;
    level_d        = level_q;
    sample_valid_d = 1'b0;
    // ones_cnt tops out at DECIM-1 before the last bit, so the sum fits SAMPLE_W.
    win_sum        = ones_cnt_q + SAMPLE_W'(pdm_bit);
    dev_c          = (win_sum >= MID) ? DEV_W'(win_sum - MID) : DEV_W'(MID - win_sum);
    if (!en) begin
      ones_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (sample_tick) begin
      if (bit_cnt_q == BIT_LAST) begin
        sample_d       = win_sum;
        level_d        = LEVEL_W'(dev_c);
        sample_valid_d = 1'b1;
        ones_cnt_d     = '0;
        bit_cnt_d      = '0;
      end else begin
        ones_cnt_d = win_sum;
        bit_cnt_d  = bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    clap_d     = 1'b0;
    if (!en) begin
      state_d    = QUIET;
      hold_cnt_d = '0;
    end else if (sample_valid_q) begin
      case (state_q)
        QUIET: begin
          if (level_q >= THRESH_L) begin
            clap_d     = 1'b1;
            hold_cnt_d = HOLDOFF_L;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_q == '0) begin
            state_d = REARM;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        REARM: begin
          // Re-arm only once the room has gone clearly quiet, not just under THRESH.
          if (level_q < REARM_L) begin
            state_d = QUIET;
          end
        end
        default: state_d = QUIET;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q         <= '0;
      ones_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      sample_q       <= '0;
      level_q        <= '0;
      sample_valid_q <= 1'b0;
      state_q        <= QUIET;
      hold_cnt_q     <= '0;
      clap_q         <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      ones_cnt_q     <= ones_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      sample_q       <= sample_d;
      level_q        <= level_d;
      sample_valid_q <= sample_valid_d;
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      clap_q         <= clap_d;
    end
  end

  assign mic_lrsel    = 1'b0;
  assign sample       = sample_q;
  assign level        = level_q;
  assign sample_valid = sample_valid_q;
  assign clap         = clap_q;

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// tb/tb_pdm_mic_receiver.sv - scoreboard bench for pdm_mic_receiver
module tb_pdm_mic_receiver;
  import tow_audio_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int DECIM    = 128;
  localparam int SAMPLE_W = 8;
  localparam int THRESH   = 16;
  localparam int HYST     = 4;
  localparam int HOLDOFF  = 4;
  localparam int WIN      = 2 * CLK_DIV * DECIM;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en = 1'b0;
  logic                mic_data = 1'b0;
  logic                mic_clk;
  logic                mic_lrsel;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic [SAMPLE_W-2:0] level;
  logic                clap;

  pdm_mic_receiver #(
    .CLK_DIV (CLK_DIV),
    .DECIM   (DECIM),
    .SAMPLE_W(SAMPLE_W),
    .THRESH  (THRESH),
    .HYST    (HYST),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mic_data    (mic_data),
    .mic_clk     (mic_clk),
    .mic_lrsel   (mic_lrsel),
    .sample      (sample),
    .sample_valid(sample_valid),
    .level       (level),
    .clap        (clap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int pat_q[$];
  int cur_pat = 0;
  int m_cnt = 0;
  int m_ones = 0;
  int sv_cnt = 0;
  int clap_cnt = 0;
  int last_sv_cyc = 0;
  int prev_sv_cyc = 0;
  logic prev_sv = 1'b0;

  // pattern >= 0: that many leading ones in the window; -1: alternating 0/1
  function automatic logic pick(input int pat, input int idx);
    if (pat < 0) return idx[0];
    return (idx < pat);
  endfunction

  // Reference window model: one bit per falling mic_clk while enabled.
  initial begin
    forever begin
      @(negedge mic_clk);
      if (rst === 1'b0 && en === 1'b1) begin
        m_ones += (mic_data ? 1 : 0);
        m_cnt++;
        if (m_cnt == DECIM) begin
          exp_q.push_back(m_ones);
          m_ones = 0;
          m_cnt  = 0;
          if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
        end
        #1 mic_data = pick(cur_pat, m_cnt);
      end
    end
  end

  // Output monitor: pops the scoreboard on each sample_valid.
  initial begin
    int e;
    int e_lvl;
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        n_vec++;
        if (prev_sv) begin
          n_err++;
          $display("FAIL sv_width: sample_valid high %0d cycles, required 1", 2);
        end
        sv_cnt++;
        prev_sv_cyc = last_sv_cyc;
        last_sv_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_sample: got sample=%0d, required none", sample);
        end else begin
          e = exp_q.pop_front();
          e_lvl = (e >= DECIM / 2) ? e - DECIM / 2 : DECIM / 2 - e;
          n_vec++;
          if (sample !== SAMPLE_W'(e)) begin
            n_err++;
            $display("FAIL sample: got %0d, required %0d", sample, e);
          end
          n_vec++;
          if (level !== (SAMPLE_W - 1)'(e_lvl)) begin
            n_err++;
            $display("FAIL level: got %0d, required %0d", level, e_lvl);
          end
        end
      end
      if (clap === 1'b1) begin
        clap_cnt++;
        n_vec++;
        if (prev_sv !== 1'b1) begin
          n_err++;
          $display("FAIL clap_timing: clap without sample_valid the cycle before");
        end
      end
      prev_sv = (sample_valid === 1'b1);
    end
  end

  task automatic model_start();
    m_cnt  = 0;
    m_ones = 0;
    if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
    mic_data = pick(cur_pat, 0);
  endtask

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    model_start();
    en = 1'b1;
  endtask

  task automatic wait_samples(input int n);
    int target;
    int t;
    target = sv_cnt + n;
    t = 0;
    while (sv_cnt < target && t < (n + 1) * WIN) begin
      @(negedge clk);
      t++;
    end
    if (sv_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL sample_timeout: got %0d samples, required %0d", sv_cnt, target);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic next_rise(output int at_cyc);
    logic was;
    int t;
    was = mic_clk;
    t = 0;
    at_cyc = -1;
    while (t < 4 * CLK_DIV + 4) begin
      @(negedge clk);
      t++;
      if (mic_clk === 1'b1 && was === 1'b0) begin
        at_cyc = cyc;
        break;
      end
      was = mic_clk;
    end
  endtask

  task automatic check_state(input clap_state_e s, input string tag);
    n_vec++;
    if (dut.state_q !== s) begin
      n_err++;
      $display("FAIL state_%s: got %0d, required %0d", tag, dut.state_q, s);
    end
  endtask

  task automatic check_claps(input int got, input int want, input string tag);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL claps_%s: got %0d, required %0d", tag, got, want);
    end
  endtask

  task automatic check_drained(input string tag);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drained_%s: %0d expected samples never arrived, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({mic_clk, mic_lrsel, sample, level, sample_valid, clap} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got mic_clk=%b lrsel=%b sample=%0d level=%0d sv=%b clap=%b, required all 0",
               mic_clk, mic_lrsel, sample, level, sample_valid, clap);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (mic_clk !== 1'b0 || mic_lrsel !== 1'b0) begin
      n_err++;
      $display("FAIL idle_disabled: got mic_clk=%b lrsel=%b, required 0 0", mic_clk, mic_lrsel);
    end
  endtask

  task automatic test_all_ones();
    int c0;
    int st;
    c0 = clap_cnt;
    repeat (3) pat_q.push_back(DECIM);
    restart();
    st = cyc;
    wait_samples(1);
    n_vec++;
    if (last_sv_cyc - st !== WIN) begin
      n_err++;
      $display("FAIL first_latency: got %0d, required %0d", last_sv_cyc - st, WIN);
    end
    wait_samples(2);
    n_vec++;
    if (last_sv_cyc - prev_sv_cyc !== WIN) begin
      n_err++;
      $display("FAIL sample_period: got %0d, required %0d", last_sv_cyc - prev_sv_cyc, WIN);
    end
    check_claps(clap_cnt - c0, 1, "all_ones");
    check_drained("all_ones");
  endtask

  task automatic test_alternating();
    int c0;
    int a;
    int b;
    c0 = clap_cnt;
    repeat (3) pat_q.push_back(-1);
    restart();
    next_rise(a);
    next_rise(b);
    n_vec++;
    if (a < 0 || b - a !== 2 * CLK_DIV) begin
      n_err++;
      $display("FAIL mic_clk_period: got %0d, required %0d", b - a, 2 * CLK_DIV);
    end
    wait_samples(3);
    check_claps(clap_cnt - c0, 0, "alternating");
    check_drained("alternating");
  endtask

  task automatic test_holdoff();
    int c0;
    c0 = clap_cnt;
    repeat (10) pat_q.push_back(DECIM);
    pat_q.push_back(DECIM / 2);
    pat_q.push_back(DECIM);
    restart();
    wait_samples(5);
    check_state(HOLD, "after5");
    wait_samples(1);
    check_state(REARM, "after6");
    wait_samples(4);
    check_state(REARM, "loud_held");
    check_claps(clap_cnt - c0, 1, "loud_burst");
    wait_samples(1);
    check_state(QUIET, "quiet");
    wait_samples(1);
    check_state(HOLD, "second_burst");
    check_claps(clap_cnt - c0, 2, "two_bursts");
    check_drained("holdoff");
  endtask

  task automatic test_hysteresis();
    int c0;
    c0 = clap_cnt;
    pat_q.push_back(DECIM);
    repeat (5) pat_q.push_back(78);
    pat_q.push_back(76);
    pat_q.push_back(84);
    pat_q.push_back(74);
    pat_q.push_back(80);
    restart();
    wait_samples(6);
    check_state(REARM, "lvl14");
    wait_samples(1);
    check_state(REARM, "lvl12_edge");
    wait_samples(1);
    check_state(REARM, "lvl20");
    check_claps(clap_cnt - c0, 1, "no_rearm_clap");
    wait_samples(1);
    check_state(QUIET, "lvl10");
    wait_samples(1);
    check_claps(clap_cnt - c0, 2, "lvl16");
    check_drained("hysteresis");
  endtask

  task automatic test_en_drop();
    int c0;
    int sv0;
    int t;
    int highs;
    int st;
    int r;
    c0 = clap_cnt;
    pat_q.push_back(100);
    pat_q.push_back(100);
    restart();
    t = 0;
    while (m_cnt != 60 && t < WIN) begin
      @(negedge clk);
      t++;
    end
    en = 1'b0;
    sv0 = sv_cnt;
    highs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (mic_clk !== 1'b0) highs++;
    end
    n_vec++;
    if (highs !== 0) begin
      n_err++;
      $display("FAIL mic_clk_disabled: got %0d high cycles, required 0", highs);
    end
    n_vec++;
    if (sv_cnt !== sv0) begin
      n_err++;
      $display("FAIL valid_disabled: got %0d samples, required 0", sv_cnt - sv0);
    end
    model_start();
    en = 1'b1;
    st = cyc;
    next_rise(r);
    n_vec++;
    if (r - st !== CLK_DIV) begin
      n_err++;
      $display("FAIL first_rise: got %0d, required %0d", r - st, CLK_DIV);
    end
    wait_samples(1);
    n_vec++;
    if (last_sv_cyc - st !== WIN) begin
      n_err++;
      $display("FAIL en_latency: got %0d, required %0d", last_sv_cyc - st, WIN);
    end
    check_claps(clap_cnt - c0, 1, "en_drop");
    check_drained("en_drop");
  endtask

  task automatic test_reset_mid_hold();
    int c0;
    int t;
    int st;
    c0 = clap_cnt;
    repeat (4) pat_q.push_back(DECIM);
    restart();
    wait_samples(1);
    check_state(HOLD, "pre_reset");
    t = 0;
    while (m_cnt != 40 && t < WIN) begin
      @(negedge clk);
      t++;
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({mic_clk, sample, level, sample_valid, clap} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got mic_clk=%b sample=%0d level=%0d sv=%b clap=%b, required all 0",
               mic_clk, sample, level, sample_valid, clap);
    end
    check_state(QUIET, "in_reset");
    pat_q.delete();
    pat_q.push_back(DECIM);
    pat_q.push_back(DECIM);
    model_start();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    st = cyc;
    c0 = clap_cnt;
    wait_samples(1);
    n_vec++;
    if (last_sv_cyc - st !== WIN) begin
      n_err++;
      $display("FAIL reset_latency: got %0d, required %0d", last_sv_cyc - st, WIN);
    end
    check_claps(clap_cnt - c0, 1, "post_reset");
    check_drained("reset");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_holdoff();
    test_hysteresis();
    test_en_drop();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
